// File: rtl/uart_rx_if.sv
// Receive-side byte handshake of the UART receiver.
// The receiver drives the byte, its status flags and busy. The consumer drives ready.
interface uart_rx_if;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    modport master (
        output data,
        output valid,
        output frame_err,
        output overrun,
        output busy,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        input  frame_err,
        input  overrun,
        input  busy,
        output ready
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver. It samples each bit at mid-bit from a synchronized rx line and
// delivers bytes through a valid/ready handshake with frame-error and overrun pulses.
module uart_rx #(
    parameter int CLK_FREQ = 12_000_000,
    parameter int BAUD     = 115_200
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      rx,
    uart_rx_if.master bus
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);

    generate
        if (CLKS_PER_BIT < 4) begin : g_cpb_check
            $error("uart_rx: CLK_FREQ/BAUD must be at least 4");
        end
    endgenerate

    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_IDLE
    } state_e;

    state_e           state_q, state_d;
    logic             rx_meta_q, rx_meta_d;
    logic             rx_sync_q, rx_sync_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;

    always_comb begin
        // NOTE: every signal gets its default before the case, so no path can leave one unassigned and infer a latch.
        state_d     = state_q;
        rx_meta_d   = rx;
        rx_sync_d   = rx_meta_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;

        if (valid_q && bus.ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rx_sync_q) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    // A start bit that is gone by mid-bit is treated as a glitch.
                    state_d   = rx_sync_q ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d              = '0;
                    shift_d[bit_idx_q] = rx_sync_q;
                    bit_idx_d          = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    if (rx_sync_q) begin
                        // A delivery wins over a same-cycle consume; overrun only if nobody took the old byte.
                        data_d    = shift_q;
                        valid_d   = 1'b1;
                        overrun_d = valid_q && !bus.ready;
                        state_d   = S_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_WAIT_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT_IDLE: begin
                cnt_d = '0;
                if (rx_sync_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rx_meta_q   <= rx_meta_d;
            rx_sync_q   <= rx_sync_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.data      = data_q;
    assign bus.valid     = valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;
    assign bus.busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at 10 clocks per bit. Frames are driven as line-level waveforms.
// A negedge monitor logs handshakes and flag pulses against expectations kept here.
module tb_uart_rx;
    localparam int CLK_FREQ = 1_000_000;
    localparam int BAUD     = 100_000;
    localparam int CPB      = CLK_FREQ / BAUD;

    logic clk = 1'b0;
    logic rst;
    logic rx;
    uart_rx_if bus ();

    uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .clk (clk),
        .rst (rst),
        .rx  (rx),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Monitor: cycle count, valid rises, flag pulses, and bytes taken by the consumer.
    int         cyc = 0;
    logic       prev_valid = 1'b0;
    int         rise_cnt = 0;
    int         last_rise_cyc = 0;
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    int         both_cnt = 0;
    logic [7:0] got[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        prev_valid <= bus.valid;
        if (bus.valid && !prev_valid) begin
            rise_cnt      <= rise_cnt + 1;
            last_rise_cyc <= cyc;
        end
        if (bus.frame_err) fe_cnt <= fe_cnt + 1;
        if (bus.overrun) ov_cnt <= ov_cnt + 1;
        if (bus.frame_err && bus.overrun) both_cnt <= both_cnt + 1;
        if (bus.valid && bus.ready) got.push_back(bus.data);
    end

    int start_cyc = 0;

    // Each task is entered and left 1 time unit after a rising edge.
    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        start_cyc = cyc;
        rx = 1'b0;
        hold(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            hold(CPB);
        end
        rx = stop_bit;
        hold(CPB);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        rx = 1'b1;
        bus.ready = 1'b0;
        hold(3);
        @(negedge clk);
        total++; if (bus.data !== 8'h00) $display("FAIL reset_data: got %h expected 00", bus.data); else passed++;
        total++; if (bus.valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", bus.valid); else passed++;
        total++; if (bus.frame_err !== 1'b0) $display("FAIL reset_frame_err: got %b expected 0", bus.frame_err); else passed++;
        total++; if (bus.overrun !== 1'b0) $display("FAIL reset_overrun: got %b expected 0", bus.overrun); else passed++;
        total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus.busy); else passed++;
        @(posedge clk); #1;
        rst = 1'b0;
        hold(5);
    endtask

    task automatic test_single_byte;
        int r0, f0, g0, lat;
        r0 = rise_cnt; f0 = fe_cnt; g0 = got.size();
        bus.ready = 1'b0;
        send_frame(8'h52, 1'b1);
        @(negedge clk);
        lat = last_rise_cyc - start_cyc;
        total++; if (rise_cnt - r0 !== 1) $display("FAIL t1_rises: got %0d expected 1", rise_cnt - r0); else passed++;
        total++; if (lat < 95 || lat > 100) $display("FAIL t1_latency: got %0d expected 95..100", lat); else passed++;
        total++; if (bus.valid !== 1'b1) $display("FAIL t1_valid: got %b expected 1", bus.valid); else passed++;
        total++; if (bus.data !== 8'h52) $display("FAIL t1_data: got %h expected 52", bus.data); else passed++;
        total++; if (fe_cnt - f0 !== 0) $display("FAIL t1_frame_err: got %0d pulses expected 0", fe_cnt - f0); else passed++;
        @(posedge clk); #1;
        bus.ready = 1'b1;
        hold(1);
        bus.ready = 1'b0;
        @(negedge clk);
        total++; if (bus.valid !== 1'b0) $display("FAIL t1_valid_clear: got %b expected 0", bus.valid); else passed++;
        total++; if (got.size() - g0 !== 1) $display("FAIL t1_taken: got %0d bytes expected 1", got.size() - g0);
        else if (got[g0] !== 8'h52) $display("FAIL t1_taken: got %h expected 52", got[g0]); else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_glitch;
        int r0, f0, o0;
        logic busy_seen;
        r0 = rise_cnt; f0 = fe_cnt; o0 = ov_cnt;
        busy_seen = 1'b0;
        rx = 1'b0;
        hold(3);
        rx = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.busy) busy_seen = 1'b1;
        end
        total++; if (busy_seen !== 1'b1) $display("FAIL t2_busy_rise: got %b expected 1", busy_seen); else passed++;
        total++; if (bus.busy !== 1'b0) $display("FAIL t2_busy_fall: got %b expected 0", bus.busy); else passed++;
        @(posedge clk); #1;
        hold(20);
        total++; if (rise_cnt - r0 !== 0) $display("FAIL t2_valid: got %0d rises expected 0", rise_cnt - r0); else passed++;
        total++; if ((fe_cnt - f0) + (ov_cnt - o0) !== 0) $display("FAIL t2_flags: got %0d pulses expected 0", (fe_cnt - f0) + (ov_cnt - o0)); else passed++;
    endtask

    task automatic test_frame_error;
        int r0, f0, o0, g0;
        r0 = rise_cnt; f0 = fe_cnt; o0 = ov_cnt; g0 = got.size();
        bus.ready = 1'b1;
        send_frame(8'h41, 1'b0);
        hold(30);
        rx = 1'b1;
        hold(20);
        send_frame(8'h31, 1'b1);
        hold(5);
        total++; if (fe_cnt - f0 !== 1) $display("FAIL t3_frame_err: got %0d pulses expected 1", fe_cnt - f0); else passed++;
        total++; if (rise_cnt - r0 !== 1) $display("FAIL t3_rises: got %0d expected 1", rise_cnt - r0); else passed++;
        total++; if (ov_cnt - o0 !== 0) $display("FAIL t3_overrun: got %0d pulses expected 0", ov_cnt - o0); else passed++;
        total++; if (got.size() - g0 !== 1) $display("FAIL t3_bytes: got %0d bytes expected 1", got.size() - g0);
        else if (got[g0] !== 8'h31) $display("FAIL t3_bytes: got %h expected 31", got[g0]); else passed++;
        bus.ready = 1'b0;
    endtask

    task automatic test_back_to_back_overrun;
        int r0, f0, o0, g0;
        r0 = rise_cnt; f0 = fe_cnt; o0 = ov_cnt; g0 = got.size();
        bus.ready = 1'b0;
        send_frame(8'h31, 1'b1);
        send_frame(8'h36, 1'b1);
        hold(3);
        @(negedge clk);
        total++; if (bus.data !== 8'h36) $display("FAIL t4_data: got %h expected 36", bus.data); else passed++;
        total++; if (bus.valid !== 1'b1) $display("FAIL t4_valid: got %b expected 1", bus.valid); else passed++;
        total++; if (ov_cnt - o0 !== 1) $display("FAIL t4_overrun: got %0d pulses expected 1", ov_cnt - o0); else passed++;
        total++; if (rise_cnt - r0 !== 1) $display("FAIL t4_rises: got %0d expected 1", rise_cnt - r0); else passed++;
        total++; if (fe_cnt - f0 !== 0) $display("FAIL t4_frame_err: got %0d pulses expected 0", fe_cnt - f0); else passed++;
        @(posedge clk); #1;
        bus.ready = 1'b1;
        hold(1);
        bus.ready = 1'b0;
        @(negedge clk);
        total++; if (bus.valid !== 1'b0) $display("FAIL t4_valid_clear: got %b expected 0", bus.valid); else passed++;
        total++; if (got.size() - g0 !== 1) $display("FAIL t4_taken: got %0d bytes expected 1", got.size() - g0);
        else if (got[g0] !== 8'h36) $display("FAIL t4_taken: got %h expected 36", got[g0]); else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0] b;
        int r0, f0, g0;
        b = 8'h55;
        bus.ready = 1'b0;
        rx = 1'b0;
        hold(CPB);
        for (int i = 0; i < 3; i++) begin
            rx = b[i];
            hold(CPB);
        end
        rx = b[3];
        hold(CPB / 2);
        rst = 1'b1;
        hold(1);
        rst = 1'b0;
        @(negedge clk);
        total++; if (bus.data !== 8'h00) $display("FAIL t5_data: got %h expected 00", bus.data); else passed++;
        total++; if (bus.valid !== 1'b0) $display("FAIL t5_valid: got %b expected 0", bus.valid); else passed++;
        total++; if (bus.busy !== 1'b0) $display("FAIL t5_busy: got %b expected 0", bus.busy); else passed++;
        total++; if ({bus.frame_err, bus.overrun} !== 2'b00) $display("FAIL t5_flags: got %b expected 00", {bus.frame_err, bus.overrun}); else passed++;
        @(posedge clk); #1;
        // The transmitter shares the reset, so the line returns to idle.
        r0 = rise_cnt; f0 = fe_cnt; g0 = got.size();
        rx = 1'b1;
        hold(2 * 10 * CPB);
        total++; if (rise_cnt - r0 !== 0) $display("FAIL t5_no_valid: got %0d rises expected 0", rise_cnt - r0); else passed++;
        bus.ready = 1'b1;
        send_frame(8'h0A, 1'b1);
        hold(5);
        total++; if (got.size() - g0 !== 1) $display("FAIL t5_next: got %0d bytes expected 1", got.size() - g0);
        else if (got[g0] !== 8'h0A) $display("FAIL t5_next: got %h expected 0a", got[g0]); else passed++;
        total++; if (fe_cnt - f0 !== 0) $display("FAIL t5_frame_err: got %0d pulses expected 0", fe_cnt - f0); else passed++;
        bus.ready = 1'b0;
    endtask

    task automatic test_stream;
        logic [7:0] msg[10];
        int r0, f0, o0, g0;
        msg = '{8'h52, 8'h6F, 8'h6C, 8'h6C, 8'h65, 8'h64, 8'h3A, 8'h20, 8'h34, 8'h0A};
        r0 = rise_cnt; f0 = fe_cnt; o0 = ov_cnt; g0 = got.size();
        bus.ready = 1'b1;
        for (int i = 0; i < 10; i++) send_frame(msg[i], 1'b1);
        hold(5);
        total++; if (rise_cnt - r0 !== 10) $display("FAIL t6_rises: got %0d expected 10", rise_cnt - r0); else passed++;
        total++; if (got.size() - g0 !== 10) $display("FAIL t6_count: got %0d bytes expected 10", got.size() - g0); else passed++;
        for (int i = 0; i < 10; i++) begin
            if (g0 + i < got.size()) begin
                total++; if (got[g0 + i] !== msg[i]) $display("FAIL t6_byte%0d: got %h expected %h", i, got[g0 + i], msg[i]); else passed++;
            end
        end
        total++; if ((fe_cnt - f0) + (ov_cnt - o0) !== 0) $display("FAIL t6_flags: got %0d pulses expected 0", (fe_cnt - f0) + (ov_cnt - o0)); else passed++;
        bus.ready = 1'b0;
    endtask

    // Random bytes, random idle gaps and occasional bad stop bits. A good frame yields
    // its byte in order; a bad one yields one frame_err and no byte.
    task automatic test_random;
        logic [7:0] exp_q[$];
        int exp_fe, f0, o0, g0;
        logic [7:0] b;
        logic bad;
        exp_fe = 0; f0 = fe_cnt; o0 = ov_cnt; g0 = got.size();
        bus.ready = 1'b1;
        for (int n = 0; n < 16; n++) begin
            b = 8'($urandom);
            bad = ($urandom_range(0, 4) == 0);
            send_frame(b, !bad);
            if (bad) begin
                exp_fe++;
                hold($urandom_range(0, 15));
                rx = 1'b1;
                hold($urandom_range(2, 20));
            end else begin
                exp_q.push_back(b);
                hold($urandom_range(0, 20));
            end
        end
        hold(5);
        total++; if (fe_cnt - f0 !== exp_fe) $display("FAIL rnd_frame_err: got %0d pulses expected %0d", fe_cnt - f0, exp_fe); else passed++;
        total++; if (ov_cnt - o0 !== 0) $display("FAIL rnd_overrun: got %0d pulses expected 0", ov_cnt - o0); else passed++;
        total++; if (got.size() - g0 !== exp_q.size()) $display("FAIL rnd_count: got %0d bytes expected %0d", got.size() - g0, exp_q.size()); else passed++;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (g0 + i < got.size()) begin
                total++; if (got[g0 + i] !== exp_q[i]) $display("FAIL rnd_byte%0d: got %h expected %h", i, got[g0 + i], exp_q[i]); else passed++;
            end
        end
        bus.ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_glitch();
        test_frame_error();
        test_back_to_back_overrun();
        test_reset_mid_frame();
        test_stream();
        test_random();
        total++; if (both_cnt !== 0) $display("FAIL flags_exclusive: got %0d shared cycles expected 0", both_cnt); else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
